// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter for the shared sprite/background ROM read port, with tagged data return.
// Define SPRITE_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration without a rotating pointer.
module sprite_rom_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 24,
    parameter int ROM_LAT = 1
) (
    input  logic                      Clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    output logic [N_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_rdata,
    output logic [N_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] cand;
    logic            win_any;
    logic            fire;

    // Tag pipeline: stage 0 lines up with rom_addr, stage ROM_LAT with rom_rdata.
    logic [ROM_LAT:0] pipe_vld;
    logic [ID_W-1:0]  pipe_id [ROM_LAT+1];

`ifndef SPRITE_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] ptr;
`endif

    always_comb begin
        win_any = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
            cand = ID_W'(k);
`else
            cand = ID_W'((int'(ptr) + k) % N_REQ);
`endif
            if (!win_any && req[cand]) begin
                win_any = 1'b1;
                win_id  = cand;
            end
        end
    end

    assign fire = win_any & enable & ~reset;

    always_comb begin
        gnt = '0;
        if (fire) gnt[win_id] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            rom_addr <= '0;
            pipe_vld <= '0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
            ptr      <= '0;
`endif
        end else begin
            pipe_vld <= {pipe_vld[ROM_LAT-1:0], fire};
            if (fire) begin
                rom_addr <= addr[win_id*ADDR_W +: ADDR_W];
`ifndef SPRITE_ARB_FIXED_PRIO_EN
                ptr      <= (int'(win_id) == N_REQ-1) ? '0 : win_id + 1'b1;
`endif
            end
        end
    end

    // Ids only matter alongside their valid bit, so they need no reset.
    always_ff @(posedge Clk) begin
        pipe_id[0] <= win_id;
        for (int s = 1; s <= ROM_LAT; s++) pipe_id[s] <= pipe_id[s-1];
    end

    always_comb begin
        rvalid = '0;
        if (pipe_vld[ROM_LAT] && !reset) rvalid[pipe_id[ROM_LAT]] = 1'b1;
    end

    assign rdata = rom_rdata;
    assign busy  = |pipe_vld;

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares the single read port of the on-chip sprite/background ROM between the per-frame drawing engines: player sprites, enemy sprites, background scroller and overlay screens (start, dead and win pictures). Each cycle it grants at most one requester in round-robin order and drives the ROM address. It tags the access so the returned data reaches only that requester after a fixed latency. It sits between the drawing engines and the ROM. The game-state controller gates it through `enable`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 16: ROM address width.
- `DATA_W`, 24: ROM data width (RGB).
- `ROM_LAT`, 1: cycles from `rom_addr` to valid `rom_rdata`, 1..4.

Ports:
- `Clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: when high, new grants are allowed.
- `req` in N_REQ: per-requester read request, level.
- `addr` in N_REQ*ADDR_W: per-requester address; slice i is `[i*ADDR_W +: ADDR_W]`.
- `gnt` out N_REQ: one-hot or zero; a request is accepted this cycle.
- `rom_addr` out ADDR_W: ROM address, registered.
- `rom_rdata` in DATA_W: ROM read data.
- `rvalid` out N_REQ: one-hot or zero; `rdata` belongs to that requester.
- `rdata` out DATA_W: `rom_rdata` passed through.
- `busy` out 1: at least one access is in flight.

## Operation
- Requester i asserts `req[i]` with a stable `addr` slice i and holds both until it samples `gnt[i]`=1.
  - It may deassert `req[i]` or present a new address in the cycle after the grant.
  - A requester may have several reads in flight.
- Arbitration is combinational from `req`, `enable` and the priority pointer `ptr` (log2 N_REQ bits).
  - The winner is the first i with `req[i]`=1, searching `ptr`, `ptr+1`, … mod N_REQ.
  - When `enable`=0 or no request is present, `gnt` is 0.
- On a grant to i:
  - `rom_addr` is loaded with `addr` slice i at the clock edge.
  - `ptr` is loaded with (i+1) mod N_REQ.
  - A tag {valid=1, id=i} enters a shift pipeline of depth 1+ROM_LAT.
- With no grant, `rom_addr` holds its value and a bubble (valid=0) enters the pipeline.
- When the pipeline output is valid, `rvalid[id]`=1; otherwise `rvalid` is 0.
- `rdata` = `rom_rdata` at all times; it is meaningful only while `rvalid` is nonzero.
- `busy` = OR of all pipeline valid bits.
- When `enable` falls, no new grants are issued. In-flight reads still complete and return normally.
- When `reset` is asserted:
  - `ptr`=0, `rom_addr`=0.
  - All pipeline valid bits are cleared, so in-flight reads are discarded and never return.
  - `gnt`=0 and `rvalid`=0 during reset.
- Reset values: `gnt`=0, `rom_addr`=0, `rvalid`=0, `busy`=0. `rdata` follows `rom_rdata`.

## Timing
- Grant at cycle t: `rom_addr` is valid in cycle t+1, and `rvalid`/`rdata` are valid in cycle t+1+ROM_LAT.
  - With ROM_LAT=1, data returns 2 cycles after the grant.
- Throughput: one grant per cycle. Back-to-back grants return back-to-back, in grant order.
- A requester that is continuously requesting waits at most N_REQ-1 cycles for a grant.
- Simultaneous requests: only one `gnt` bit is set per cycle; the losers hold their requests.
- `ptr` wraps from N_REQ-1 to 0.
- If `req[i]` rises in the same cycle `ptr` points at i, it is granted that cycle.
- `enable` takes effect combinationally in the same cycle.

## Configuration
- `SPRITE_ARB_FIXED_PRIO_EN` defined:
  - Arbitration is fixed priority, lowest index wins; `ptr` is not implemented.
  - Intended for builds where requester 0 (overlay/background) must never stall.
- Not defined: the round-robin behaviour above.
- All other behaviour is identical in both builds.

## Test plan
- Single request, ROM_LAT=1:
  - Stimulus: `req[2]`=1 with `addr`=0x0123 at cycle 5; ROM model returns 0xABCDEF for 0x0123.
  - Response: `gnt`=0b0100 at cycle 5, `rom_addr`=0x0123 at cycle 6, `rvalid`=0b0100 with `rdata`=0xABCDEF at cycle 7.
- Round-robin:
  - Stimulus: all four `req` held high from reset.
  - Response: grant sequence 0,1,2,3,0,1; `rvalid` follows the same sequence 2 cycles later, with no gaps.
- Contention:
  - Stimulus: `req[1]` and `req[3]` high, `ptr`=2.
  - Response: `gnt[3]` first, then `gnt[1]` the next cycle; `ptr` ends at 2.
- `enable` gating:
  - Stimulus: grant to 0 at cycle t, then `enable`=0 from cycle t+1 with `req[1]` held high.
  - Response: `rvalid[0]` at t+2, no `gnt` while disabled, `gnt[1]` in the cycle `enable` returns to 1.
- Reset mid-flight:
  - Stimulus: grant at cycle t, then `reset`=1 at cycle t+1.
  - Response: no `rvalid` at t+2; `busy`=0; `rom_addr`=0; after release, first grant goes to the lowest active requester.
- `SPRITE_ARB_FIXED_PRIO_EN` build:
  - Stimulus: all requests held high.
  - Response: `gnt`=0b0001 every cycle; requesters 1..3 are never granted.
